// File: rtl/spad_hit_capture.sv
// spad_hit_capture: arms on TDC_start_i, timestamps SPAD hits with a coarse count and re-arms the SPAD via rst_auto_o.
// Ports:
//   clk_250M_i    250 MHz system clock (sole clock)
//   rst_i         synchronous active-high reset
//   TDC_start_i   start pulse; accepted only while idle
//   trig_i        async SPAD trigger, held high until cleared by rst_auto_o
//   time_gate_i   async SPAD per-photon pulse; blocks rst_auto_o while high
//   spad_int_i    SPAD intensity word, quasi-static while trig_i is high
//   rst_auto_o    registered SPAD clear
//   hit_valid_o   one-cycle pulse qualifying hit_coarse_o/hit_int_o/hit_idx_o
//   meas_done_o   one-cycle pulse at end of measurement
//   hit_cnt_o     hits recorded; holds until the next accepted start
//   timeout_o     window expired; holds until the next accepted start
module spad_hit_capture #(
    parameter int COARSE_W   = 10,
    parameter int MAX_CYCLES = 512,
    parameter int MAX_HITS   = 3,
    parameter int RST_CYCLES = 2
) (
    input  logic                clk_250M_i,
    input  logic                rst_i,
    input  logic                TDC_start_i,
    input  logic                trig_i,
    input  logic                time_gate_i,
    input  logic [15:0]         spad_int_i,
    output logic                rst_auto_o,
    output logic                hit_valid_o,
    output logic [COARSE_W-1:0] hit_coarse_o,
    output logic [15:0]         hit_int_o,
    output logic [1:0]          hit_idx_o,
    output logic                meas_done_o,
    output logic [1:0]          hit_cnt_o,
    output logic                timeout_o
);
    typedef enum logic [2:0] {IDLE, ARM, RESET, RECOVER, DONE} state_t;
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [COARSE_W-1:0] LAST = COARSE_W'(MAX_CYCLES - 1);
    localparam logic [1:0] HMAX = 2'(MAX_HITS);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RST_CYCLES);
    state_t state_q, state_d;
    logic trig_m_q, trig_s_q, tg_m_q, tg_s_q;
    logic [COARSE_W-1:0] cnt_q, cnt_d, hit_coarse_q, hit_coarse_d;
    logic [1:0] hits_q, hits_d, hit_idx_q, hit_idx_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [15:0] hit_int_q, hit_int_d;
    logic rst_auto_q, rst_auto_d, hit_valid_q, hit_valid_d;
    logic meas_done_q, meas_done_d, timeout_q, timeout_d;
    logic active, expire, hit, stale;
    always_comb begin
        active = state_q inside {ARM, RESET, RECOVER};
        expire = active && cnt_q == LAST;
        // cnt is zero only in the first ARM cycle, so a trigger seen there predates the start
        stale = state_q == ARM && trig_s_q && cnt_q == '0;
        hit = state_q == ARM && trig_s_q && cnt_q != '0 && hits_q < HMAX;
        state_d = state_q;
        cnt_d = active ? cnt_q + 1'b1 : cnt_q;
        hits_d = hit ? hits_q + 1'b1 : hits_q;
        rc_d = rc_q;
        rst_auto_d = 1'b0;
        hit_valid_d = hit;
        hit_coarse_d = hit ? cnt_q : hit_coarse_q;
        hit_int_d = hit ? spad_int_i : hit_int_q;
        hit_idx_d = hit ? hits_q : hit_idx_q;
        meas_done_d = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (TDC_start_i) begin
                state_d = ARM;
                cnt_d = '0;
                hits_d = '0;
                timeout_d = 1'b0;
            end
            ARM: if (hit || stale) begin
                state_d = RESET;
                rc_d = '0;
            end
            // clear pulses are only issued while the gate is low; rc counts issued pulses
            RESET: if (rc_q == RC_MAX) state_d = hits_q == HMAX ? DONE : RECOVER;
                   else begin
                       rst_auto_d = !tg_s_q;
                       rc_d = rc_q + RC_W'(!tg_s_q);
                   end
            RECOVER: if (!trig_s_q) state_d = ARM;
            DONE: begin
                meas_done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // window expiry wins over everything except recording a coincident hit
        if (expire) begin
            state_d = DONE;
            timeout_d = 1'b1;
            rst_auto_d = 1'b0;
        end
    end
    always_ff @(posedge clk_250M_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            trig_m_q <= 1'b0;
            trig_s_q <= 1'b0;
            tg_m_q <= 1'b0;
            tg_s_q <= 1'b0;
            cnt_q <= '0;
            hits_q <= '0;
            rc_q <= '0;
            rst_auto_q <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_coarse_q <= '0;
            hit_int_q <= '0;
            hit_idx_q <= '0;
            meas_done_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_m_q <= trig_i;
            trig_s_q <= trig_m_q;
            tg_m_q <= time_gate_i;
            tg_s_q <= tg_m_q;
            cnt_q <= cnt_d;
            hits_q <= hits_d;
            rc_q <= rc_d;
            rst_auto_q <= rst_auto_d;
            hit_valid_q <= hit_valid_d;
            hit_coarse_q <= hit_coarse_d;
            hit_int_q <= hit_int_d;
            hit_idx_q <= hit_idx_d;
            meas_done_q <= meas_done_d;
            timeout_q <= timeout_d;
        end
    end
    assign rst_auto_o = rst_auto_q;
    assign hit_valid_o = hit_valid_q;
    assign hit_coarse_o = hit_coarse_q;
    assign hit_int_o = hit_int_q;
    assign hit_idx_o = hit_idx_q;
    assign meas_done_o = meas_done_q;
    assign hit_cnt_o = hits_q;
    assign timeout_o = timeout_q;
endmodule
